// File: rtl/arb_pkg.sv
// Shared types for the two-port memory arbiter.
// Arbiter state and requester port identifiers.
package arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    typedef enum logic {
        ARB_CORE = 1'b0,
        ARB_DBG  = 1'b1
    } arb_port_t;

endpackage

// File: rtl/arb_watchdog.sv
// Saturating busy-cycle counter for the memory arbiter.
// Raises o_timeout once the count reaches TIMEOUT; TIMEOUT = 0 disables it.
module arb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_timeout
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != LIMIT)) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_timeout = (TIMEOUT != 0) && (r_count == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the core (0)
// and the debug loader (1), with a timeout error response.
module mem_arbiter
    import arb_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             m0_read,
    input  logic             m0_write,
    input  logic [WIDTH-1:0] m0_addr,
    input  logic [WIDTH-1:0] m0_wdata,
    output logic [WIDTH-1:0] m0_rdata,
    output logic             m0_resp,
    output logic             m0_err,
    input  logic             m1_read,
    input  logic             m1_write,
    input  logic [WIDTH-1:0] m1_addr,
    input  logic [WIDTH-1:0] m1_wdata,
    output logic [WIDTH-1:0] m1_rdata,
    output logic             m1_resp,
    output logic             m1_err,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             mem_read,
    output logic             mem_write,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_resp,
    output logic             owner
);

    arb_state_t r_state;
    arb_port_t  r_last;

    logic             w_req0;
    logic             w_req1;
    logic             w_grant;
    logic             w_busy;
    logic             w_timeout;
    logic             w_ok;
    logic             w_to;
    arb_port_t        w_win;
    logic             w_sel_rd;
    logic             w_sel_wr;
    logic [WIDTH-1:0] w_sel_addr;
    logic [WIDTH-1:0] w_sel_wdata;

    assign w_req0  = m0_read | m0_write;
    assign w_req1  = m1_read | m1_write;
    assign w_busy  = (r_state == ARB_BUSY);
    assign w_grant = (r_state == ARB_IDLE) && (w_req0 || w_req1);

    // On contention the port that did not win last time goes next.
    always_comb begin
        w_win = ARB_CORE;
        if (w_req0 && w_req1) begin
            w_win = (r_last == ARB_CORE) ? ARB_DBG : ARB_CORE;
        end else if (w_req1) begin
            w_win = ARB_DBG;
        end
    end

    assign w_sel_rd    = (w_win == ARB_DBG) ? m1_read  : m0_read;
    assign w_sel_wr    = (w_win == ARB_DBG) ? m1_write : m0_write;
    assign w_sel_addr  = (w_win == ARB_DBG) ? m1_addr  : m0_addr;
    assign w_sel_wdata = (w_win == ARB_DBG) ? m1_wdata : m0_wdata;

    arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_grant),
        .i_enable  (w_busy && !mem_resp),
        .o_timeout (w_timeout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ARB_IDLE;
            r_last    <= ARB_DBG;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
        end else begin
            unique case (r_state)
                ARB_IDLE: begin
                    if (w_grant) begin
                        r_last    <= w_win;
                        mem_addr  <= w_sel_addr;
                        mem_wdata <= w_sel_wdata;
                        mem_write <= w_sel_wr;
                        mem_read  <= w_sel_rd & ~w_sel_wr;
                        r_state   <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    if (mem_resp) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        r_state   <= ARB_IDLE;
                    end else if (w_timeout) begin
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        r_state   <= ARB_IDLE;
                    end
                end
            endcase
        end
    end

    // A real memory answer beats a timeout landing in the same cycle.
    assign w_ok = w_busy && mem_resp;
    assign w_to = w_busy && w_timeout && !mem_resp;

    assign m0_resp  = (w_ok || w_to) && (r_last == ARB_CORE);
    assign m1_resp  = (w_ok || w_to) && (r_last == ARB_DBG);
    assign m0_err   = w_to && (r_last == ARB_CORE);
    assign m1_err   = w_to && (r_last == ARB_DBG);
    assign m0_rdata = (w_ok && (r_last == ARB_CORE)) ? mem_rdata : '0;
    assign m1_rdata = (w_ok && (r_last == ARB_DBG))  ? mem_rdata : '0;
    assign owner    = r_last;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter (TIMEOUT = 4).
// Directed scenarios plus a randomized round-robin reference model.
module tb_mem_arbiter;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         m0_read, m0_write, m1_read, m1_write;
    logic [W-1:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [W-1:0] m0_rdata, m1_rdata;
    logic         m0_resp, m0_err, m1_resp, m1_err;
    logic [W-1:0] mem_addr, mem_wdata, mem_rdata;
    logic         mem_read, mem_write, mem_resp;
    logic         owner;

    int checks   = 0;
    int failures = 0;

    mem_arbiter #(
        .WIDTH   (W),
        .TIMEOUT (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m0_read   (m0_read),
        .m0_write  (m0_write),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_rdata  (m0_rdata),
        .m0_resp   (m0_resp),
        .m0_err    (m0_err),
        .m1_read   (m1_read),
        .m1_write  (m1_write),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_rdata  (m1_rdata),
        .m1_resp   (m1_resp),
        .m1_err    (m1_err),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_rdata (mem_rdata),
        .mem_resp  (mem_resp),
        .owner     (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        m0_read = 0; m0_write = 0; m0_addr = '0; m0_wdata = '0;
        m1_read = 0; m1_write = 0; m1_addr = '0; m1_wdata = '0;
        mem_rdata = '0; mem_resp = 0;
    endtask

    task automatic apply_reset;
        rst_n = 0;
        clear_inputs();
        tick();
        tick();
        rst_n = 1;
    endtask

    task automatic test_reset;
        rst_n = 1;
        clear_inputs();
        #2;
        rst_n = 0;
        #2;
        checks++;
        if ({mem_read, mem_write} !== 2'b00) begin
            failures++;
            $display("FAIL reset_rw: got %b want 00", {mem_read, mem_write});
        end
        checks++;
        if ({mem_addr, mem_wdata} !== '0) begin
            failures++;
            $display("FAIL reset_bus: got %h %h want 0", mem_addr, mem_wdata);
        end
        checks++;
        if ({m0_resp, m0_err, m1_resp, m1_err} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_resp: got %b want 0000",
                     {m0_resp, m0_err, m1_resp, m1_err});
        end
        checks++;
        if ({m0_rdata, m1_rdata} !== '0) begin
            failures++;
            $display("FAIL reset_rdata: got %h %h want 0", m0_rdata, m1_rdata);
        end
        checks++;
        if (owner !== 1'b1) begin
            failures++;
            $display("FAIL reset_owner: got %b want 1", owner);
        end
        tick();
        tick();
        rst_n = 1;
    endtask

    task automatic test_idle_resp;
        mem_resp  = 1;
        mem_rdata = 32'h5555_AAAA;
        #1;
        checks++;
        if ({m0_resp, m1_resp} !== 2'b00 || {m0_rdata, m1_rdata} !== '0) begin
            failures++;
            $display("FAIL idle_resp: got %b %h %h want 00 0 0",
                     {m0_resp, m1_resp}, m0_rdata, m1_rdata);
        end
        tick();
        mem_resp = 0;
        #1;
        checks++;
        if ({mem_read, mem_write} !== 2'b00) begin
            failures++;
            $display("FAIL idle_resp_bus: got %b want 00", {mem_read, mem_write});
        end
    endtask

    task automatic test_single_read;
        m0_read = 1;
        m0_addr = 32'h0000_1000;
        #1;
        checks++;
        if (mem_read !== 1'b0) begin
            failures++;
            $display("FAIL single_latency: got %b want 0", mem_read);
        end
        tick();
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (mem_read !== 1'b1 || mem_write !== 1'b0 ||
                mem_addr !== 32'h0000_1000) begin
                failures++;
                $display("FAIL single_bus: got r%b w%b %h want r1 w0 00001000",
                         mem_read, mem_write, mem_addr);
            end
            checks++;
            if (m0_resp !== 1'b0 || m1_resp !== 1'b0) begin
                failures++;
                $display("FAIL single_early: got %b%b want 00", m0_resp, m1_resp);
            end
            tick();
        end
        mem_resp  = 1;
        mem_rdata = 32'hDEAD_BEEF;
        m0_read   = 0;
        #1;
        checks++;
        if (m0_resp !== 1'b1 || m0_rdata !== 32'hDEAD_BEEF || m0_err !== 1'b0) begin
            failures++;
            $display("FAIL single_resp: got %b %h e%b want 1 deadbeef e0",
                     m0_resp, m0_rdata, m0_err);
        end
        checks++;
        if (m1_resp !== 1'b0 || m1_rdata !== '0) begin
            failures++;
            $display("FAIL single_other: got %b %h want 0 0", m1_resp, m1_rdata);
        end
        tick();
        mem_resp = 0;
        #1;
        checks++;
        if (mem_read !== 1'b0) begin
            failures++;
            $display("FAIL single_done: got %b want 0", mem_read);
        end
    endtask

    task automatic test_fairness;
        apply_reset();
        m0_read = 1; m0_addr = 32'h100;
        m1_read = 1; m1_addr = 32'h200;
        for (int k = 0; k < 6; k++) begin
            tick();
            #1;
            checks++;
            if (owner !== k[0] || mem_read !== 1'b1) begin
                failures++;
                $display("FAIL fair_grant%0d: got owner %b rd %b want %b 1",
                         k, owner, mem_read, k[0]);
            end
            checks++;
            if (mem_addr !== (k[0] ? 32'h200 : 32'h100)) begin
                failures++;
                $display("FAIL fair_addr%0d: got %h", k, mem_addr);
            end
            tick();
            mem_resp  = 1;
            mem_rdata = 32'(k);
            #1;
            checks++;
            if ((k[0] ? m1_resp : m0_resp) !== 1'b1 ||
                (k[0] ? m0_resp : m1_resp) !== 1'b0) begin
                failures++;
                $display("FAIL fair_resp%0d: got %b%b", k, m1_resp, m0_resp);
            end
            tick();
            mem_resp = 0;
            #1;
            checks++;
            if (mem_read !== 1'b0) begin
                failures++;
                $display("FAIL fair_gap%0d: got %b want 0", k, mem_read);
            end
        end
        m0_read = 0;
        m1_read = 0;
        tick();
    endtask

    task automatic test_write_precedence;
        m1_read  = 1;
        m1_write = 1;
        m1_addr  = 32'h40;
        m1_wdata = 32'h1234_5678;
        tick();
        #1;
        checks++;
        if (mem_write !== 1'b1 || mem_read !== 1'b0 ||
            mem_wdata !== 32'h1234_5678 || owner !== 1'b1) begin
            failures++;
            $display("FAIL wr_prec: got w%b r%b %h o%b want w1 r0 12345678 o1",
                     mem_write, mem_read, mem_wdata, owner);
        end
        mem_resp = 1;
        m1_read  = 0;
        m1_write = 0;
        #1;
        checks++;
        if (m1_resp !== 1'b1 || m0_resp !== 1'b0) begin
            failures++;
            $display("FAIL wr_resp: got %b%b want 10", m1_resp, m0_resp);
        end
        tick();
        mem_resp = 0;
    endtask

    task automatic test_timeout(input bit race);
        m0_read = 1;
        m0_addr = 32'h0000_0BAD;
        tick();
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (m0_resp !== 1'b0 || m0_err !== 1'b0) begin
                failures++;
                $display("FAIL to_early%0d: got %b%b want 00", i, m0_resp, m0_err);
            end
            tick();
        end
        mem_rdata = 32'hCAFE_F00D;
        mem_resp  = race;
        m0_read   = 0;
        #1;
        checks++;
        if (m0_resp !== 1'b1 || m0_err !== !race ||
            m0_rdata !== (race ? 32'hCAFE_F00D : 32'h0)) begin
            failures++;
            $display("FAIL to_resp%0d: got %b e%b %h", race, m0_resp, m0_err, m0_rdata);
        end
        checks++;
        if (m1_resp !== 1'b0 || m1_err !== 1'b0) begin
            failures++;
            $display("FAIL to_other%0d: got %b%b want 00", race, m1_resp, m1_err);
        end
        tick();
        mem_resp = 0;
        #1;
        checks++;
        if (m0_resp !== 1'b0 || mem_read !== 1'b0) begin
            failures++;
            $display("FAIL to_release%0d: got %b %b want 0 0", race, m0_resp, mem_read);
        end
        m1_write = 1;
        m1_addr  = 32'h88;
        m1_wdata = 32'h77;
        tick();
        #1;
        checks++;
        if (mem_write !== 1'b1 || owner !== 1'b1 || mem_addr !== 32'h88) begin
            failures++;
            $display("FAIL to_next%0d: got w%b o%b %h", race, mem_write, owner, mem_addr);
        end
        mem_resp = 1;
        m1_write = 0;
        #1;
        checks++;
        if (m1_resp !== 1'b1 || m1_err !== 1'b0) begin
            failures++;
            $display("FAIL to_next_resp%0d: got %b e%b", race, m1_resp, m1_err);
        end
        tick();
        mem_resp = 0;
    endtask

    task automatic test_reset_mid;
        m1_read = 1;
        m1_addr = 32'h300;
        tick();
        #1;
        checks++;
        if (mem_read !== 1'b1 || owner !== 1'b1) begin
            failures++;
            $display("FAIL mid_start: got %b o%b want 1 1", mem_read, owner);
        end
        tick();
        rst_n    = 0;
        mem_resp = 1;
        #1;
        checks++;
        if (mem_read !== 1'b0 || mem_addr !== '0) begin
            failures++;
            $display("FAIL mid_abort: got %b %h want 0 0", mem_read, mem_addr);
        end
        checks++;
        if (m1_resp !== 1'b0 || m0_resp !== 1'b0) begin
            failures++;
            $display("FAIL mid_noresp: got %b%b want 00", m1_resp, m0_resp);
        end
        tick();
        mem_resp = 0;
        rst_n    = 1;
        m0_read  = 1;
        m0_addr  = 32'h400;
        tick();
        #1;
        checks++;
        if (owner !== 1'b0 || mem_addr !== 32'h400) begin
            failures++;
            $display("FAIL mid_after: got o%b %h want 0 400", owner, mem_addr);
        end
        mem_resp = 1;
        m0_read  = 0;
        m1_read  = 0;
        tick();
        mem_resp = 0;
    endtask

    // Reference: one outstanding transfer; on contention the port not
    // granted last time wins; write beats read; any requester is served.
    task automatic test_random;
        int           last;
        int           win;
        int           d;
        bit           r0, r1;
        logic [1:0]   op0, op1;
        logic [W-1:0] a0, a1, w0, w1, rd;
        logic [W-1:0] ea, ew;
        logic         ewr;
        apply_reset();
        last = 1;
        for (int it = 0; it < 40; it++) begin
            r0  = 1'($urandom_range(0, 1));
            r1  = 1'($urandom_range(0, 1));
            if (!r0 && !r1) r1 = 1;
            op0 = 2'($urandom_range(1, 3));
            op1 = 2'($urandom_range(1, 3));
            a0 = $urandom; a1 = $urandom; w0 = $urandom; w1 = $urandom;
            m0_read = r0 & op0[0]; m0_write = r0 & op0[1];
            m1_read = r1 & op1[0]; m1_write = r1 & op1[1];
            m0_addr = a0; m0_wdata = w0; m1_addr = a1; m1_wdata = w1;
            win  = (r0 && r1) ? 1 - last : (r0 ? 0 : 1);
            last = win;
            ea   = win ? a1 : a0;
            ew   = win ? w1 : w0;
            ewr  = win ? op1[1] : op0[1];
            tick();
            #1;
            checks++;
            if (owner !== win[0] || mem_addr !== ea || mem_wdata !== ew ||
                mem_write !== ewr || mem_read !== !ewr) begin
                failures++;
                $display("FAIL rnd_grant%0d: got o%b %h %h w%b r%b want o%0d %h %h w%b",
                         it, owner, mem_addr, mem_wdata, mem_write, mem_read,
                         win, ea, ew, ewr);
            end
            d = $urandom_range(0, 3);
            for (int c = 0; c < d; c++) begin
                m0_read = 1'($urandom); m0_write = 1'($urandom); m0_addr = $urandom;
                m1_read = 1'($urandom); m1_write = 1'($urandom); m1_addr = $urandom;
                #1;
                checks++;
                if (m0_resp !== 1'b0 || m1_resp !== 1'b0 || mem_addr !== ea ||
                    mem_write !== ewr) begin
                    failures++;
                    $display("FAIL rnd_hold%0d: got %b%b %h want 00 %h",
                             it, m1_resp, m0_resp, mem_addr, ea);
                end
                tick();
            end
            rd = $urandom;
            mem_rdata = rd;
            mem_resp  = 1;
            m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
            #1;
            checks++;
            if ((win ? m1_resp : m0_resp) !== 1'b1 ||
                (win ? m1_rdata : m0_rdata) !== rd ||
                (win ? m0_resp : m1_resp) !== 1'b0 ||
                (win ? m0_rdata : m1_rdata) !== '0 ||
                {m0_err, m1_err} !== 2'b00) begin
                failures++;
                $display("FAIL rnd_resp%0d: got r%b%b d%h/%h want port %0d data %h",
                         it, m1_resp, m0_resp, m1_rdata, m0_rdata, win, rd);
            end
            tick();
            mem_resp = 0;
            #1;
            checks++;
            if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
                failures++;
                $display("FAIL rnd_gap%0d: got r%b w%b want 0 0", it, mem_read, mem_write);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL sim_timeout: got no finish want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_idle_resp();
        test_single_read();
        test_fairness();
        test_write_precedence();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
